pbus_master: RTL and testbench

PBUS_MASTER -- requirements
Module: pbus_master

---
 rtl/pbus_master_pkg.sv | 31 +++
 rtl/pbus_master.sv | 183 ++++++++++++++++++
 tb/tb_pbus_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pbus_master_pkg.sv
// Shared definitions for the peripheral bus master: widths, FSM encoding,
// peripheral register offsets and the latched poll-compare payload.
package pbus_master_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned WAIT_W    = 4;
    localparam int unsigned ATTEMPT_W = 16;

    // Peripheral register offsets
    localparam logic [ADDR_W-1:0] REG_IO0  = 8'h00;
    localparam logic [ADDR_W-1:0] REG_DIR0 = 8'h04;
    localparam logic [ADDR_W-1:0] REG_IO1  = 8'h08;
    localparam logic [ADDR_W-1:0] REG_DIR1 = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Poll compare payload latched at request accept
    typedef struct packed {
        logic              poll;
        logic [DATA_W-1:0] match;
        logic [DATA_W-1:0] mask;
    } poll_cfg_t;

endpackage

// File: rtl/pbus_master.sv
// Request/response master for a simple peripheral register bus.
// Optional polling (repeat reads until masked compare hits or attempt limit)
// is built only when PBUS_MASTER_POLL_EN is defined.
module pbus_master
    import pbus_master_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned POLL_LIMIT  = 256
) (
    input  logic              clk_bus,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_mask,
    input  logic              req_poll,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              bus_read,
    output logic              bus_write
);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                req_ready_d, rsp_valid_d, rsp_timeout_d;
    logic                bus_read_d, bus_write_d;
    logic [DATA_W-1:0]   rsp_rdata_d, bus_data_o_d;
    logic [ADDR_W-1:0]   bus_address_d;

`ifdef PBUS_MASTER_POLL_EN
    poll_cfg_t            cfg_q, cfg_d;
    logic [ATTEMPT_W-1:0] attempt_q, attempt_d;
    logic                 hit_c;

    // Masked compare of the last captured read against the poll match value
    assign hit_c = ((rdata_q & cfg_q.mask) == (cfg_q.match & cfg_q.mask));
`else
    logic unused_c;
    assign unused_c = ^{req_poll, req_mask};
`endif

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            rdata_q     <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            bus_read    <= 1'b0;
            bus_write   <= 1'b0;
            bus_address <= '0;
            bus_data_o  <= '0;
`ifdef PBUS_MASTER_POLL_EN
            cfg_q       <= '0;
            attempt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rdata_q     <= rdata_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_timeout <= rsp_timeout_d;
            bus_read    <= bus_read_d;
            bus_write   <= bus_write_d;
            bus_address <= bus_address_d;
            bus_data_o  <= bus_data_o_d;
`ifdef PBUS_MASTER_POLL_EN
            cfg_q       <= cfg_d;
            attempt_q   <= attempt_d;
`endif
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        rdata_d       = rdata_q;
        req_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata;
        rsp_timeout_d = rsp_timeout;
        bus_read_d    = 1'b0;
        bus_write_d   = 1'b0;
        bus_address_d = bus_address;
        bus_data_o_d  = bus_data_o;
`ifdef PBUS_MASTER_POLL_EN
        cfg_d         = cfg_q;
        attempt_d     = attempt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_d   = 1'b0;
                    wait_d        = '0;
                    bus_address_d = req_addr;
`ifdef PBUS_MASTER_POLL_EN
                    // A write never polls, even with req_poll set
                    cfg_d     = '{poll: req_poll && !req_write, match: req_wdata, mask: req_mask};
                    attempt_d = '0;
`endif
                    if (req_write) begin
                        state_d      = ST_WRITE;
                        bus_write_d  = 1'b1;
                        bus_data_o_d = req_wdata;
                    end else begin
                        state_d    = ST_READ;
                        bus_read_d = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                state_d       = ST_RESP;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = '0;
                rsp_timeout_d = 1'b0;
            end

            ST_READ: begin
                // Hold bus_read for WAIT_CYCLES extra cycles, sample on the last one
                if (wait_q == WAIT_W'(WAIT_CYCLES)) begin
                    rdata_d = bus_data_i;
                    state_d = ST_CHECK;
                end else begin
                    wait_d     = wait_q + WAIT_W'(1);
                    bus_read_d = 1'b1;
                end
            end

            ST_CHECK: begin
                state_d       = ST_RESP;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = rdata_q;
                rsp_timeout_d = 1'b0;
`ifdef PBUS_MASTER_POLL_EN
                if (cfg_q.poll && !hit_c) begin
                    attempt_d = attempt_q + ATTEMPT_W'(1);
                    if (attempt_d == ATTEMPT_W'(POLL_LIMIT)) begin
                        rsp_timeout_d = 1'b1;
                    end else begin
                        state_d     = ST_READ;
                        rsp_valid_d = 1'b0;
                        rsp_rdata_d = rsp_rdata;
                        wait_d      = '0;
                        bus_read_d  = 1'b1;
                    end
                end
`endif
            end

            ST_RESP: begin
                rsp_valid_d = 1'b1;
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pbus_master.sv
// Self-checking bench for pbus_master: scoreboarded responses, latency,
// bus activity and reset-abort behaviour. Expectations follow PBUS_MASTER_POLL_EN.
module tb_pbus_master;

    localparam int unsigned WAIT  = 1;
    localparam int unsigned PLIM  = 4;
    localparam int          BOUND = 300;

    typedef struct {
        logic [31:0] rdata;
        logic        timeout;
        int          phases;
        int          lat;
    } exp_t;

    logic        clk_bus = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_poll;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata, req_mask;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [7:0]  bus_address;
    logic [31:0] bus_data_o, bus_data_i;
    logic        bus_read, bus_write;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb_q[$];

    // Peripheral read-data model: value switches from per_lo to per_hi at phase rise_at
    logic [31:0] per_lo, per_hi;
    int          rise_at;
    int          per_phase;
    logic        per_prev;

    pbus_master #(.WAIT_CYCLES(WAIT), .POLL_LIMIT(PLIM)) dut (
        .clk_bus(clk_bus), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask), .req_poll(req_poll),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .bus_address(bus_address), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
        .bus_read(bus_read), .bus_write(bus_write)
    );

    always #5 clk_bus = ~clk_bus;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_at(input int n);
        return (n >= rise_at) ? per_hi : per_lo;
    endfunction

    function automatic exp_t model(input logic wr, input logic poll,
                                   input logic [31:0] wdata, input logic [31:0] mask);
        exp_t e;
        int   n;
        logic eff_poll;
        e.timeout = 1'b0;
        if (wr) begin
            e.rdata = '0; e.phases = 0; e.lat = 2;
            return e;
        end
`ifdef PBUS_MASTER_POLL_EN
        eff_poll = poll;
`else
        eff_poll = 1'b0;
`endif
        n = 1;
        while (eff_poll && ((data_at(n) & mask) != (wdata & mask))) begin
            if (n == int'(PLIM)) begin
                e.timeout = 1'b1;
                break;
            end
            n++;
        end
        e.rdata  = data_at(n);
        e.phases = n;
        e.lat    = n * (int'(WAIT) + 2) + 1;
        return e;
    endfunction

    // Peripheral: count read phases and present the matching read data
    always @(negedge clk_bus) begin
        if (bus_read && !per_prev) per_phase = per_phase + 1;
        per_prev   = bus_read;
        bus_data_i = data_at(per_phase);
    end

    // Response monitor: pop the scoreboard on each handshake
    always @(negedge clk_bus) begin
        exp_t e;
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else if (rsp_ready) begin
                e = sb_q.pop_front();
                check_eq("rsp_rdata", rsp_rdata, e.rdata);
                check_eq("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
            end
        end
    end

    task automatic run_req(input logic wr, input logic poll, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] mask, input int hold);
        exp_t e;
        int   k, phases, rd_cycles, wr_cycles, overlap;
        logic prev;
        e = model(wr, poll, wdata, mask);
        @(posedge clk_bus); #1;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        per_phase = 0;
        req_valid = 1'b1; req_write = wr; req_poll = poll;
        req_addr = addr; req_wdata = wdata; req_mask = mask;
        sb_q.push_back(e);
        @(posedge clk_bus); #1;
        req_valid = 1'b0;
        k = 1; phases = 0; rd_cycles = 0; wr_cycles = 0; overlap = 0; prev = 1'b0;
        while (!rsp_valid && k < BOUND) begin
            if (wr && k == 1) begin
                check_eq("wr_addr", 32'(bus_address), 32'(addr));
                check_eq("wr_data", bus_data_o, wdata);
            end
            if (bus_read && !prev) phases++;
            if (bus_read) rd_cycles++;
            if (bus_write) wr_cycles++;
            if (bus_read && bus_write) overlap++;
            if (req_ready) overlap++;
            prev = bus_read;
            @(posedge clk_bus); #1;
            k++;
        end
        check_eq("rsp_latency", 32'(k), 32'(e.lat));
        check_eq("rd_phases", 32'(phases), 32'(e.phases));
        check_eq("rd_cycles", 32'(rd_cycles), 32'(e.phases * (int'(WAIT) + 1)));
        check_eq("wr_cycles", 32'(wr_cycles), wr ? 32'd1 : 32'd0);
        check_eq("bus_overlap_or_ready", 32'(overlap), 32'd0);
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_rdata", rsp_rdata, e.rdata);
            check_eq("hold_timeout", 32'(rsp_timeout), 32'(e.timeout));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk_bus); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk_bus); #1;
        rsp_ready = 1'b0;
        check_eq("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check_eq("req_ready_back", 32'(req_ready), 32'd1);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_poll = 1'b0;
        req_addr = '0; req_wdata = '0; req_mask = '0; rsp_ready = 1'b0;
        per_lo = '0; per_hi = '0; rise_at = 1000; per_phase = 0; per_prev = 1'b0;
        bus_data_i = '0;
        repeat (3) @(posedge clk_bus);
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check_eq("rst_bus_rw", 32'({bus_read, bus_write}), 32'd0);
        check_eq("rst_bus_address", 32'(bus_address), 32'd0);
        check_eq("rst_bus_data_o", bus_data_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk_bus); #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);

        // Plain write
        run_req(1'b1, 1'b0, 8'h04, 32'h0000_FFFF, 32'h0, 0);
        // Plain read with response back-pressure
        per_lo = 32'hA5A5_0001; per_hi = 32'hA5A5_0001; rise_at = 1000;
        run_req(1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 10);
        // Poll that matches on the fourth read
        per_lo = 32'h0; per_hi = 32'h1; rise_at = 4;
        run_req(1'b0, 1'b1, 8'h08, 32'h1, 32'h1, 0);
        // Poll that never matches
        per_lo = 32'h0; per_hi = 32'h0; rise_at = 1000;
        run_req(1'b0, 1'b1, 8'h08, 32'h1, 32'h1, 2);
        // Multi-bit mask poll matching on the second read
        per_lo = 32'h0000_000F; per_hi = 32'hFFFF_FF3F; rise_at = 2;
        run_req(1'b0, 1'b1, 8'h0C, 32'h0000_0030, 32'h0000_00F0, 1);
        // Write with poll set behaves as a plain write
        run_req(1'b1, 1'b1, 8'h08, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);

        // Random plain reads and writes
        for (int i = 0; i < 6; i++) begin
            per_lo = $urandom; per_hi = per_lo; rise_at = 1000;
            run_req(1'($urandom_range(1)), 1'b0, 8'($urandom), $urandom, 32'h0,
                    int'($urandom_range(3)));
        end

        // Reset in the middle of a read phase
        per_lo = 32'h1234_5678; per_hi = per_lo; rise_at = 1000;
        @(posedge clk_bus); #1;
        req_valid = 1'b1; req_write = 1'b0; req_poll = 1'b0; req_addr = 8'h08;
        @(posedge clk_bus); #1;
        req_valid = 1'b0;
        check_eq("abort_bus_read_pre", 32'(bus_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_bus_read", 32'(bus_read), 32'd0);
        check_eq("abort_bus_address", 32'(bus_address), 32'd0);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk_bus); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_bus); #1;
            check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
            check_eq("abort_no_bus", 32'({bus_read, bus_write}), 32'd0);
        end
        rsp_ready = 1'b0;
        check_eq("abort_req_ready", 32'(req_ready), 32'd1);
        per_lo = 32'h0BAD_F00D; per_hi = per_lo;
        run_req(1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
